// File: rtl/axi_riscv_lrsc_table.sv
// LR/SC reservation table: tracks up to N_SLOTS reservations (one per owner ID)
// at granule resolution, invalidated by snooped writes, SC outcomes and an
// optional age timeout. SC requests get a registered pass/fail response.
module axi_riscv_lrsc_table #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned N_SLOTS        = 4,
    parameter int unsigned ADDR_LSB       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           lr_valid_i,
    output logic                           lr_ready_o,
    input  logic [ADDR_WIDTH-1:0]          lr_addr_i,
    input  logic [ID_WIDTH-1:0]            lr_id_i,
    input  logic                           sc_valid_i,
    output logic                           sc_ready_o,
    input  logic [ADDR_WIDTH-1:0]          sc_addr_i,
    input  logic [ID_WIDTH-1:0]            sc_id_i,
    output logic                           sc_resp_valid_o,
    input  logic                           sc_resp_ready_i,
    output logic                           sc_resp_ok_o,
    output logic [ID_WIDTH-1:0]            sc_resp_id_o,
    input  logic                           wr_valid_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    output logic [$clog2(N_SLOTS+1)-1:0]   occupancy_o
);

    localparam int unsigned GRAN_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned PTR_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int unsigned AGE_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned OCC_W     = $clog2(N_SLOTS + 1);
    localparam bit          EXPIRE_EN = (TIMEOUT_CYCLES > 0);
    localparam int unsigned AGE_MAX   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_MAX);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_SLOTS - 1);

    logic [N_SLOTS-1:0] valid_q, valid_d;
    logic [ID_WIDTH-1:0] id_q [N_SLOTS];
    logic [ID_WIDTH-1:0] id_d [N_SLOTS];
    logic [GRAN_W-1:0]   gran_q [N_SLOTS];
    logic [GRAN_W-1:0]   gran_d [N_SLOTS];
    logic [AGE_W-1:0]    age_q [N_SLOTS];
    logic [AGE_W-1:0]    age_d [N_SLOTS];
    logic [PTR_W-1:0]    ptr_q, ptr_d;

    logic                resp_valid_q, resp_valid_d;
    logic                resp_ok_q, resp_ok_d;
    logic [ID_WIDTH-1:0] resp_id_q, resp_id_d;
    logic [OCC_W-1:0]    occ_q, occ_d;

    logic [GRAN_W-1:0] lr_gran, sc_gran, wr_gran;
    logic              sc_fire, sc_hit, lr_hit, lr_free;
    logic [PTR_W-1:0]  lr_slot, free_slot;

    // Granule offset bits never participate in matching.
    logic unused_low_bits;
    assign unused_low_bits = ^{lr_addr_i[ADDR_LSB-1:0], sc_addr_i[ADDR_LSB-1:0],
                               wr_addr_i[ADDR_LSB-1:0]};

    assign lr_gran = lr_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign sc_gran = sc_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_gran = wr_addr_i[ADDR_WIDTH-1:ADDR_LSB];

    assign lr_ready_o      = !rst_i;
    assign sc_ready_o      = !resp_valid_q | sc_resp_ready_i;
    assign sc_fire         = sc_valid_i & sc_ready_o;
    assign sc_resp_valid_o = resp_valid_q;
    assign sc_resp_ok_o    = resp_ok_q;
    assign sc_resp_id_o    = resp_id_q;
    assign occupancy_o     = occ_q;

    // Next table state: expiry, then write snoop, then SC, then LR, in that order.
    always_comb begin
        valid_d      = valid_q;
        id_d         = id_q;
        gran_d       = gran_q;
        age_d        = age_q;
        ptr_d        = ptr_q;
        resp_valid_d = resp_valid_q;
        resp_ok_d    = resp_ok_q;
        resp_id_d    = resp_id_q;
        sc_hit       = 1'b0;
        lr_hit       = 1'b0;
        lr_free      = 1'b0;
        lr_slot      = '0;
        free_slot    = '0;
        occ_d        = '0;

        // Ageing and expiry of start-of-cycle entries.
        for (int i = 0; i < N_SLOTS; i++) begin
            if (EXPIRE_EN && valid_q[i]) begin
                if (age_q[i] == AGE_LAST) begin
                    valid_d[i] = 1'b0;
                end else begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end

        // Committed writes kill every reservation on their granule.
        for (int i = 0; i < N_SLOTS; i++) begin
            if (wr_valid_i && gran_q[i] == wr_gran) begin
                valid_d[i] = 1'b0;
            end
        end

        for (int i = 0; i < N_SLOTS; i++) begin
            if (valid_d[i] && id_q[i] == sc_id_i && gran_q[i] == sc_gran) begin
                sc_hit = 1'b1;
            end
        end

        // A successful SC consumes the granule for everyone; a failed one drops
        // only the requester's own reservation.
        if (sc_fire) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (sc_hit ? (gran_q[i] == sc_gran) : (id_q[i] == sc_id_i)) begin
                    valid_d[i] = 1'b0;
                end
            end
            resp_valid_d = 1'b1;
            resp_ok_d    = sc_hit;
            resp_id_d    = sc_id_i;
        end else if (sc_resp_ready_i) begin
            resp_valid_d = 1'b0;
        end

        // LR slot choice: same ID in place, else lowest free, else round-robin victim.
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!lr_hit && valid_d[i] && id_q[i] == lr_id_i) begin
                lr_hit  = 1'b1;
                lr_slot = PTR_W'(i);
            end
            if (!lr_free && !valid_d[i]) begin
                lr_free   = 1'b1;
                free_slot = PTR_W'(i);
            end
        end

        if (lr_valid_i) begin
            if (!lr_hit) begin
                if (lr_free) begin
                    lr_slot = free_slot;
                end else begin
                    lr_slot = ptr_q;
                    ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
                end
            end
            valid_d[lr_slot] = 1'b1;
            id_d[lr_slot]    = lr_id_i;
            gran_d[lr_slot]  = lr_gran;
            age_d[lr_slot]   = '0;
        end

        for (int i = 0; i < N_SLOTS; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // Table, victim pointer, SC response and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_id_q    <= '0;
            occ_q        <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                id_q[i]   <= '0;
                gran_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            resp_id_q    <= resp_id_d;
            occ_q        <= occ_d;
            for (int i = 0; i < N_SLOTS; i++) begin
                id_q[i]   <= id_d[i];
                gran_q[i] <= gran_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

endmodule
